// File: rtl/rail_sequencer.sv
// rail_sequencer: N-rail power sequencer; rails come up in index order qualified on power-good
// and drop in reverse order. Define RAIL_SEQ_RETRY_EN to add timed auto-retry after a fault.
module rail_sequencer #(
   parameter int unsigned NUM_RAILS    = 4,
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned PG_TIMEOUT   = 65536,
   parameter int unsigned PG_DEBOUNCE  = 16,
   parameter int unsigned SETTLE_TICKS = 4096,
   parameter int unsigned OFF_TICKS    = 1024,
   parameter int unsigned RETRY_TICKS  = 262144,
   parameter int unsigned MAX_RETRIES  = 3,
   localparam int unsigned IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
   input  logic                 sysclk,
   input  logic                 reset_INV,
   input  logic                 enable,
   input  logic [NUM_RAILS-1:0] pg,
   output logic [NUM_RAILS-1:0] en,
   output logic                 all_good,
   output logic                 fault,
   output logic [IDX_W-1:0]     fault_rail,
   output logic [2:0]           state
);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StUp        = 3'd1,
      StSettle    = 3'd2,
      StRun       = 3'd3,
      StDown      = 3'd4,
      StFault     = 3'd5,
      StRetryWait = 3'd6
   } state_e;

   // Counters compare against "last tick" values so the event lands exactly N ticks after entry.
   localparam cnt_t TimeoutLast = cnt_t'(PG_TIMEOUT - 1);
   localparam cnt_t DebLast     = cnt_t'(PG_DEBOUNCE - 1);
   localparam cnt_t SettleLast  = cnt_t'(SETTLE_TICKS - 1);
   localparam cnt_t OffLast     = cnt_t'(OFF_TICKS - 1);
   localparam idx_t LastIdx     = idx_t'(NUM_RAILS - 1);

   state_e               state_q, state_d;
   idx_t                 idx_q, idx_d;
   cnt_t                 tick_q, tick_d;
   cnt_t                 deb_q, deb_d;
   logic [NUM_RAILS-1:0] en_q, en_d;
   logic                 all_good_q, all_good_d;
   logic                 fault_q, fault_d;
   idx_t                 fault_rail_q, fault_rail_d;
   logic [NUM_RAILS-1:0] sync_q, pgs_q;

   logic [NUM_RAILS-1:0] qual_mask;
   logic                 pg_fail;
   idx_t                 fail_idx;
   logic                 qual;
   logic                 timeout;
   idx_t                 idx_nx;

`ifdef RAIL_SEQ_RETRY_EN
   localparam cnt_t       RetryLast  = cnt_t'(RETRY_TICKS - 1);
   localparam logic [1:0] MaxRetries = 2'(MAX_RETRIES);
   logic [1:0] retries_q, retries_d;
`else
   logic unused_retry_cfg;
   assign unused_retry_cfg = ^{RETRY_TICKS, MAX_RETRIES};
`endif

   always_ff @(posedge sysclk or negedge reset_INV) begin
      if (!reset_INV) begin
         sync_q <= '0;
         pgs_q  <= '0;
      end else begin
         sync_q <= pg;
         pgs_q  <= sync_q;
      end
   end

   // Qualified rails: all enabled rails, except the one still being debounced in UP.
   always_comb begin
      qual_mask = en_q;
      if (state_q == StUp) begin
         qual_mask[idx_q] = 1'b0;
      end
      pg_fail  = 1'b0;
      fail_idx = '0;
      for (int unsigned j = 0; j < NUM_RAILS; j++) begin
         if (qual_mask[j] && !pgs_q[j] && !pg_fail) begin
            pg_fail  = 1'b1;
            fail_idx = idx_t'(j);
         end
      end
   end

   assign qual    = pgs_q[idx_q] && (deb_q == DebLast);
   assign timeout = (state_q == StUp) && (tick_q == TimeoutLast) && !qual;
   assign idx_nx  = idx_q + idx_t'(1);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tick_d       = tick_q;
      deb_d        = deb_q;
      en_d         = en_q;
      all_good_d   = all_good_q;
      fault_d      = fault_q;
      fault_rail_d = fault_rail_q;
`ifdef RAIL_SEQ_RETRY_EN
      retries_d    = retries_q;
`endif
      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StUp;
               idx_d   = '0;
               tick_d  = '0;
               deb_d   = '0;
               en_d    = '0;
               en_d[0] = 1'b1;
            end
         end
         StUp, StSettle, StRun: begin
            if (pg_fail || timeout) begin
               state_d      = StFault;
               en_d         = '0;
               all_good_d   = 1'b0;
               fault_d      = 1'b1;
               fault_rail_d = pg_fail ? fail_idx : idx_q;
               tick_d       = '0;
               deb_d        = '0;
            end else if (!enable) begin
               state_d      = StDown;
               en_d[idx_q]  = 1'b0;
               all_good_d   = 1'b0;
               tick_d       = '0;
               deb_d        = '0;
            end else if (state_q == StUp) begin
               tick_d = tick_q + cnt_t'(1);
               deb_d  = pgs_q[idx_q] ? deb_q + cnt_t'(1) : '0;
               if (qual) begin
                  tick_d = '0;
                  deb_d  = '0;
                  if (idx_q == LastIdx) begin
                     state_d = StSettle;
                  end else begin
                     idx_d        = idx_nx;
                     en_d[idx_nx] = 1'b1;
                  end
               end
            end else if (state_q == StSettle) begin
               tick_d = tick_q + cnt_t'(1);
               if (tick_q == SettleLast) begin
                  state_d    = StRun;
                  all_good_d = 1'b1;
                  tick_d     = '0;
`ifdef RAIL_SEQ_RETRY_EN
                  retries_d  = '0;
`endif
               end
            end
         end
         StDown: begin
            tick_d = tick_q + cnt_t'(1);
            if (tick_q == OffLast) begin
               tick_d = '0;
               if (idx_q == '0) begin
                  state_d = StIdle;
               end else begin
                  idx_d                     = idx_q - idx_t'(1);
                  en_d[idx_q - idx_t'(1)]   = 1'b0;
               end
            end
         end
`ifdef RAIL_SEQ_RETRY_EN
         StFault: begin
            if (retries_q == MaxRetries) begin
               if (!enable) begin
                  state_d   = StIdle;
                  fault_d   = 1'b0;
                  retries_d = '0;
               end
            end else begin
               state_d = StRetryWait;
               tick_d  = '0;
            end
         end
         StRetryWait: begin
            if (!enable) begin
               state_d   = StIdle;
               fault_d   = 1'b0;
               retries_d = '0;
               tick_d    = '0;
            end else begin
               tick_d = tick_q + cnt_t'(1);
               if (tick_q == RetryLast) begin
                  retries_d = retries_q + 2'd1;
                  fault_d   = 1'b0;
                  state_d   = StUp;
                  idx_d     = '0;
                  tick_d    = '0;
                  deb_d     = '0;
                  en_d      = '0;
                  en_d[0]   = 1'b1;
               end
            end
         end
`else
         StFault: begin
            if (!enable) begin
               state_d = StIdle;
               fault_d = 1'b0;
            end
         end
`endif
         default: begin
            state_d    = StIdle;
            en_d       = '0;
            all_good_d = 1'b0;
            tick_d     = '0;
            deb_d      = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_INV) begin
      if (!reset_INV) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         tick_q       <= '0;
         deb_q        <= '0;
         en_q         <= '0;
         all_good_q   <= 1'b0;
         fault_q      <= 1'b0;
         fault_rail_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         tick_q       <= tick_d;
         deb_q        <= deb_d;
         en_q         <= en_d;
         all_good_q   <= all_good_d;
         fault_q      <= fault_d;
         fault_rail_q <= fault_rail_d;
      end
   end

`ifdef RAIL_SEQ_RETRY_EN
   always_ff @(posedge sysclk or negedge reset_INV) begin
      if (!reset_INV) begin
         retries_q <= '0;
      end else begin
         retries_q <= retries_d;
      end
   end
`endif

   assign en         = en_q;
   assign all_good   = all_good_q;
   assign fault      = fault_q;
   assign fault_rail = fault_rail_q;
   assign state      = state_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Directed bench for rail_sequencer (3 rails, short timings); checks exact edge-level latencies.
module tb_rail_sequencer;

   logic       sysclk = 1'b0;
   logic       reset_INV;
   logic       enable;
   logic [2:0] pg;
   logic [2:0] en;
   logic       all_good;
   logic       fault;
   logic [1:0] fault_rail;
   logic [2:0] state;

   int passed = 0;
   int total  = 0;

   rail_sequencer #(
      .NUM_RAILS   (3),
      .CNT_W       (24),
      .PG_TIMEOUT  (100),
      .PG_DEBOUNCE (4),
      .SETTLE_TICKS(10),
      .OFF_TICKS   (8),
      .RETRY_TICKS (50),
      .MAX_RETRIES (3)
   ) dut (
      .sysclk    (sysclk),
      .reset_INV (reset_INV),
      .enable    (enable),
      .pg        (pg),
      .en        (en),
      .all_good  (all_good),
      .fault     (fault),
      .fault_rail(fault_rail),
      .state     (state)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   // pg[i] goes high 5 ticks after en[i]; qualification lands 2 sync + 4 debounce ticks later.
   task automatic rail_up(input int i, input logic [2:0] en_hold, input logic [2:0] en_next,
                          input logic [2:0] st_next);
      repeat (5) tick();
      pg[i] = 1'b1;
      repeat (5) tick();
      chk("up_hold_en", en, en_hold);
      tick();
      chk("up_next_en", en, en_next);
      chk("up_next_state", state, st_next);
   endtask

   task automatic back_to_idle();
      enable = 1'b0;
      pg     = '0;
      repeat (3) tick();
      chk("idle_state", state, 0);
      chk("idle_fault", fault, 0);
   endtask

   initial begin
      int   rises;
      logic prev;
      reset_INV = 1'b0;
      enable    = 1'b0;
      pg        = '0;
      repeat (3) tick();
      chk("rst_en", en, 0);
      chk("rst_all_good", all_good, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_rail", fault_rail, 0);
      chk("rst_state", state, 0);
      reset_INV = 1'b1;
      tick();

      // Power-up
      enable = 1'b1;
      tick();
      chk("pu_en0", en, 3'b001);
      chk("pu_state", state, 1);
      rail_up(0, 3'b001, 3'b011, 3'd1);
      rail_up(1, 3'b011, 3'b111, 3'd1);
      rail_up(2, 3'b111, 3'b111, 3'd2);
      repeat (9) tick();
      chk("settle_ag", all_good, 0);
      chk("settle_state", state, 2);
      tick();
      chk("run_ag", all_good, 1);
      chk("run_state", state, 3);
      chk("run_en", en, 3'b111);

      // Power-down
      enable = 1'b0;
      tick();
      chk("dn_en_011", en, 3'b011);
      chk("dn_state", state, 4);
      chk("dn_ag", all_good, 0);
      repeat (7) tick();
      chk("dn_hold_011", en, 3'b011);
      tick();
      chk("dn_en_001", en, 3'b001);
      repeat (8) tick();
      chk("dn_en_000", en, 3'b000);
      repeat (7) tick();
      chk("dn_still_down", state, 4);
      tick();
      chk("dn_idle", state, 0);
      chk("dn_fault", fault, 0);
      pg = '0;

      // Debounce restart on rail 1, then RUN glitch on rail 2
      enable = 1'b1;
      tick();
      rail_up(0, 3'b001, 3'b011, 3'd1);
      repeat (5) tick();
      pg[1] = 1'b1;
      repeat (3) tick();
      pg[1] = 1'b0;
      repeat (2) tick();
      pg[1] = 1'b1;
      repeat (5) tick();
      chk("deb_restart_en", en, 3'b011);
      chk("deb_restart_fault", fault, 0);
      tick();
      chk("deb_qual_en", en, 3'b111);
      rail_up(2, 3'b111, 3'b111, 3'd2);
      repeat (10) tick();
      chk("gl_run", state, 3);
      pg[2] = 1'b0;
      tick();
      pg[2] = 1'b1;
      tick();
      chk("gl_sync_en", en, 3'b111);
      tick();
      chk("gl_en", en, 3'b000);
      chk("gl_fault", fault, 1);
      chk("gl_rail", fault_rail, 2);
      chk("gl_state", state, 5);
      chk("gl_ag", all_good, 0);
      back_to_idle();

      // Timeout on rail 1
      enable = 1'b1;
      tick();
      rail_up(0, 3'b001, 3'b011, 3'd1);
      repeat (99) tick();
      chk("to_hold_en", en, 3'b011);
      chk("to_hold_state", state, 1);
      tick();
      chk("to_en", en, 3'b000);
      chk("to_fault", fault, 1);
      chk("to_rail", fault_rail, 1);
      chk("to_state", state, 5);
      back_to_idle();

      // Fault beats enable deassert
      enable = 1'b1;
      tick();
      rail_up(0, 3'b001, 3'b011, 3'd1);
      pg[0] = 1'b0;
      tick();
      tick();
      chk("pri_pre_en", en, 3'b011);
      enable = 1'b0;
      tick();
      chk("pri_state", state, 5);
      chk("pri_rail", fault_rail, 0);
      chk("pri_en", en, 3'b000);
      chk("pri_fault", fault, 1);
      back_to_idle();

      // Async reset mid-UP
      enable = 1'b1;
      repeat (3) tick();
      chk("ar_pre_en", en, 3'b001);
      #2;
      reset_INV = 1'b0;
      #1;
      chk("ar_en", en, 3'b000);
      chk("ar_state", state, 0);
      enable = 1'b0;
      tick();
      reset_INV = 1'b1;
      tick();
      chk("ar_fault", fault, 0);

      // pg[0] never rises
      enable = 1'b1;
      pg     = '0;
`ifdef RAIL_SEQ_RETRY_EN
      rises = 0;
      prev  = 1'b0;
      for (int c = 0; c < 900; c++) begin
         tick();
         if (en[0] && !prev) rises++;
         prev = en[0];
      end
      chk("rt_enables", rises, 4);
      chk("rt_fault", fault, 1);
      chk("rt_state", state, 5);
      chk("rt_en", en, 3'b000);
`else
      rises = 0;
      prev  = 1'b0;
      tick();
      chk("nr_en0", en, 3'b001);
      repeat (99) tick();
      chk("nr_hold_en", en, 3'b001);
      tick();
      chk("nr_fault", fault, 1);
      chk("nr_rail", fault_rail, 0);
      for (int c = 0; c < 300; c++) begin
         tick();
         if (en[0] && !prev) rises++;
         prev = en[0];
      end
      chk("nr_no_reenable", rises, 0);
      chk("nr_sticky_fault", fault, 1);
      chk("nr_sticky_state", state, 5);
`endif
      back_to_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
